// File: rtl/grv_bus_pkg.sv
// grv_bus_pkg: shared state, payload types and default widths for the memory-bus arbiters
package grv_bus_pkg;
   localparam int NUM_REQ_D = 2;
   localparam int ADDR_W_D = 32;
   localparam int DATA_W_D = 64;
   localparam int TIMEOUT_CYC_D = 256;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_e;
   typedef struct packed {
      logic [ADDR_W_D-1:0] addr;
      logic [DATA_W_D-1:0] wdata;
      logic [DATA_W_D/8-1:0] wmask;
      logic wen;
   } mem_req_t;
   function automatic int wrap_inc(int i, int n);
      return (i + 1 == n) ? 0 : i + 1;
   endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester-side and memory-side signals of the shared memory port
interface mem_bus_arbiter_if import grv_bus_pkg::*; #(
   parameter int NUM_REQ = NUM_REQ_D,
   parameter int ADDR_W = ADDR_W_D,
   parameter int DATA_W = DATA_W_D
);
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ*DATA_W/8-1:0] req_wmask;
   logic [NUM_REQ-1:0] req_wen;
   logic [NUM_REQ-1:0] resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic resp_err;
   logic mem_req_valid;
   logic mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W/8-1:0] mem_wmask;
   logic mem_wen;
   logic mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_rdata;
   modport slave (
      input req_valid, req_addr, req_wdata, req_wmask, req_wen, mem_req_ready, mem_resp_valid, mem_resp_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_req_valid, mem_addr, mem_wdata, mem_wmask, mem_wen
   );
   modport master (
      output req_valid, req_addr, req_wdata, req_wmask, req_wen, mem_req_ready, mem_resp_valid, mem_resp_rdata,
      input req_ready, resp_valid, resp_rdata, resp_err, mem_req_valid, mem_addr, mem_wdata, mem_wmask, mem_wen
   );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// rr_pick: first set valid bit at or after start, wrapping; one-hot grant plus its index
module rr_pick #(
   parameter int N = 2,
   parameter int IW = $clog2(N)
) (
   input logic [N-1:0] valid,
   input logic [IW-1:0] start,
   output logic [N-1:0] grant,
   output logic [IW-1:0] idx,
   output logic hit
);
   logic [IW-1:0] j;
   always_comb begin
      grant = '0;
      idx = '0;
      hit = 1'b0;
      j = '0;
      for (int i = 0; i < N; i++) begin
         j = IW'((int'(start) + i) % N);
         if (!hit && valid[j]) begin
            hit = 1'b1;
            idx = j;
            grant[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin share of one memory port, one transaction in flight, watchdog error response
module mem_bus_arbiter import grv_bus_pkg::*; #(
   parameter int NUM_REQ = NUM_REQ_D,
   parameter int ADDR_W = ADDR_W_D,
   parameter int DATA_W = DATA_W_D,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_D
) (
   input logic clock,
   input logic reset,
   mem_bus_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam int MW = DATA_W / 8;
   arb_state_e state;
   logic [IW-1:0] rr_ptr, owner, win;
   logic [CW-1:0] cnt;
   logic [NUM_REQ-1:0] grant;
   logic hit, accept, hs, got, tmo, done;
   rr_pick #(.N(NUM_REQ)) u_pick (.valid(bus.req_valid), .start(rr_ptr), .grant(grant), .idx(win), .hit(hit));
   assign accept = state == IDLE && hit;
   assign hs = state == REQ && bus.mem_req_ready;
   assign got = bus.mem_resp_valid && (hs || state == WAIT);
   // a real response arriving on the timeout cycle wins over the error
   assign tmo = state == WAIT && cnt == CW'(TIMEOUT_CYC) && !bus.mem_resp_valid;
   assign done = got || tmo;
   assign bus.req_ready = accept ? grant : '0;
   assign bus.resp_valid = done ? (NUM_REQ'(1) << owner) : '0;
   assign bus.resp_err = tmo;
   assign bus.resp_rdata = got ? bus.mem_resp_rdata : '0;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= IDLE;
         rr_ptr <= '0;
         owner <= '0;
         cnt <= '0;
         bus.mem_req_valid <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wmask <= '0;
         bus.mem_wen <= 1'b0;
      end else begin
         if (accept) begin
            state <= REQ;
            owner <= win;
            rr_ptr <= IW'(wrap_inc(int'(win), NUM_REQ));
            bus.mem_req_valid <= 1'b1;
            bus.mem_addr <= bus.req_addr[win*ADDR_W +: ADDR_W];
            bus.mem_wdata <= bus.req_wdata[win*DATA_W +: DATA_W];
            bus.mem_wmask <= bus.req_wmask[win*MW +: MW];
            bus.mem_wen <= bus.req_wen[win];
         end
         if (hs) begin
            bus.mem_req_valid <= 1'b0;
            cnt <= '0;
            state <= got ? IDLE : WAIT;
         end
         if (state == WAIT) begin
            cnt <= (cnt == CW'(TIMEOUT_CYC)) ? cnt : cnt + 1'b1;
            if (done) state <= IDLE;
         end
      end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table of transactions against a response scoreboard, plus reset corner sequences
module tb_mem_bus_arbiter;
   import grv_bus_pkg::*;
   localparam int TMO = 8;
   typedef struct {
      logic [1:0] mask;
      int who;
      logic [31:0] addr;
      logic wen;
      int acc;
      int rsp;
      logic [63:0] rdata;
   } vec_t;
   typedef struct {
      logic [1:0] vld;
      logic err;
      logic [63:0] rdata;
      logic data_ok;
      int cyc;
   } exp_t;
   logic clock, reset;
   int passed = 0, total = 0;
   exp_t sb[$];
   vec_t tbl[9];
   mem_bus_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(64)) bus();
   mem_bus_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(TMO)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus.slave)
   );
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end
   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h", n, act, exp);
   endtask
   task automatic drive(logic [1:0] mask, logic [31:0] addr, logic wen);
      for (int r = 0; r < 2; r++) begin
         bus.req_addr[r*32 +: 32] = addr + 32'(r * 16);
         bus.req_wdata[r*64 +: 64] = {addr, 32'(r)};
         bus.req_wmask[r*8 +: 8] = (r == 0) ? 8'h0F : 8'hF0;
      end
      bus.req_wen = {wen, wen};
      bus.req_valid = mask;
   endtask
   function automatic mem_req_t payload(int r, logic [31:0] addr, logic wen);
      mem_req_t p;
      p.addr = addr + 32'(r * 16);
      p.wdata = {addr, 32'(r)};
      p.wmask = (r == 0) ? 8'h0F : 8'hF0;
      p.wen = wen;
      return p;
   endfunction
   task automatic resp_check(int k);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         $display("FAIL resp_unexpected: resp_valid %b with nothing outstanding", bus.resp_valid);
         return;
      end
      e = sb.pop_front();
      chk("resp_valid", 64'(bus.resp_valid), 64'(e.vld));
      chk("resp_err", 64'(bus.resp_err), 64'(e.err));
      if (e.data_ok) chk("resp_rdata", bus.resp_rdata, e.rdata);
      chk("resp_cycle", 64'(k), 64'(e.cyc));
   endtask
   task automatic run_vec(int id, vec_t v);
      mem_req_t p;
      bit seen;
      p = payload(v.who, v.addr, v.wen);
      seen = 1'b0;
      @(negedge clock);
      bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = v.rdata;
      drive(v.mask, v.addr, v.wen);
      #1;
      chk("accept", 64'(bus.req_ready), 64'(2'b01 << v.who));
      chk("ready_onehot", 64'($onehot0(bus.req_ready)), 64'd1);
      chk("mem_idle", 64'(bus.mem_req_valid), 64'd0);
      sb.push_back('{vld: 2'b01 << v.who, err: v.rsp < 0, rdata: (v.rsp < 0) ? 64'd0 : v.rdata,
                     data_ok: !v.wen || v.rsp < 0, cyc: (v.rsp < 0) ? TMO + 1 : v.rsp});
      for (int k = 0; k <= v.acc; k++) begin
         @(negedge clock);
         drive(2'b00, 32'hFFFF_0000, ~v.wen);
         bus.mem_req_ready = (k == v.acc);
         bus.mem_resp_valid = (k == v.acc) && (v.rsp == 0);
         #1;
         chk("mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
         chk("mem_addr", 64'(bus.mem_addr), 64'(p.addr));
         chk("busy_ready", 64'(bus.req_ready), 64'd0);
      end
      chk("mem_wdata", bus.mem_wdata, p.wdata);
      chk("mem_wmask", 64'(bus.mem_wmask), 64'(p.wmask));
      chk("mem_wen", 64'(bus.mem_wen), 64'(p.wen));
      if (|bus.resp_valid) begin
         resp_check(0);
         seen = 1'b1;
      end
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clock);
         bus.mem_req_ready = 1'b0;
         bus.mem_resp_valid = (k == v.rsp);
         #1;
         if (|bus.resp_valid) begin
            resp_check(k);
            seen = 1'b1;
         end
      end
      if (!seen) begin
         total++;
         $display("FAIL resp_arrive vec %0d: no response within 20 cycles", id);
      end
   endtask
   initial begin
      tbl[0] = '{2'b10, 1, 32'h8000_0000, 1'b0, 0, 2, 64'hDEAD_BEEF_0000_0001};
      tbl[1] = '{2'b11, 0, 32'h8000_1000, 1'b1, 5, 1, 64'h0000_0000_0000_1111};
      tbl[2] = '{2'b11, 1, 32'h8000_2000, 1'b0, 0, 0, 64'h2222_3333_4444_5555};
      tbl[3] = '{2'b11, 0, 32'h8000_3000, 1'b0, 0, 0, 64'h0123_4567_89AB_CDEF};
      tbl[4] = '{2'b11, 1, 32'h8000_4000, 1'b0, 1, 3, 64'hCAFE_F00D_0000_0004};
      tbl[5] = '{2'b01, 0, 32'h8000_5000, 1'b0, 0, -1, 64'hBAD0_BAD0_BAD0_BAD0};
      tbl[6] = '{2'b01, 0, 32'h8000_6000, 1'b1, 0, 2, 64'h0000_0000_0000_0006};
      tbl[7] = '{2'b10, 1, 32'h8000_7000, 1'b0, 2, 5, 64'h7777_0000_0000_0007};
      tbl[8] = '{2'b11, 0, 32'h8000_8000, 1'b0, 0, 1, 64'h8888_0000_0000_0008};
      reset = 1'b1;
      drive(2'b00, 32'h0, 1'b0);
      bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = 64'h0;
      @(negedge clock);
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
      chk("rst_resp", {61'd0, bus.resp_valid, bus.resp_err}, 64'd0);
      chk("rst_rdata", bus.resp_rdata, 64'd0);
      chk("rst_payload", {bus.mem_addr, bus.mem_wmask, 23'd0, bus.mem_wen}, 64'd0);
      chk("rst_wdata", bus.mem_wdata, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);
      @(negedge clock);
      bus.mem_resp_valid = 1'b0;
      drive(2'b01, 32'h0000_1000, 1'b0);
      #1;
      chk("mid_accept", 64'(bus.req_ready), 64'd1);
      @(negedge clock);
      drive(2'b00, 32'h0000_1000, 1'b0);
      bus.mem_req_ready = 1'b1;
      #1;
      chk("mid_handshake", 64'(bus.mem_req_valid), 64'd1);
      @(negedge clock);
      bus.mem_req_ready = 1'b0;
      #1;
      chk("mid_wait_quiet", 64'(bus.resp_valid), 64'd0);
      #2;
      reset = 1'b1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = 64'h5555_AAAA_5555_AAAA;
      #1;
      chk("async_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
      chk("async_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("async_resp", {61'd0, bus.resp_valid, bus.resp_err}, 64'd0);
      chk("async_rdata", bus.resp_rdata, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      bus.mem_resp_valid = 1'b0;
      drive(2'b11, 32'h0000_2000, 1'b0);
      #1;
      chk("post_rst_tie", 64'(bus.req_ready), 64'd1);
      @(negedge clock);
      drive(2'b00, 32'h0000_2000, 1'b0);
      bus.mem_resp_valid = 1'b1;
      #1;
      chk("req_resp_ignored", 64'(bus.resp_valid), 64'd0);
      chk("post_rst_addr", 64'(bus.mem_addr), 64'h0000_2000);
      if (sb.size() != 0) begin
         total++;
         $display("FAIL sb_drain: %0d responses never arrived, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares SimTop's single simulation-memory port between NUM_REQ core requesters (requester 0 = instruction fetch, 1 = load/store unit). Requesters are served in round-robin order, with one transaction outstanding at a time. A watchdog terminates any transaction whose response never arrives, so a hung memory model shows up as an error response rather than a silent simulation stall. The block sits between the core's memory clients and the memory model inside SimTop.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 64, data width; mask width is DATA_W/8
- TIMEOUT_CYC, 256, maximum cycles spent in WAIT before an error response
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared immediately on assertion
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_addr  in  NUM_REQ*ADDR_W  packed per-requester address
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_wmask  in  NUM_REQ*DATA_W/8  packed byte-enable mask
- req_wen  in  NUM_REQ  1 = write, 0 = read
- resp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester
- resp_rdata  out  DATA_W  shared read-data bus
- resp_err  out  1  qualifies resp_valid; high when the response is a timeout
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_addr / mem_wdata / mem_wmask / mem_wen  out  ADDR_W / DATA_W / DATA_W/8 / 1  latched request payload
- mem_resp_valid  in  1  memory response valid
- mem_resp_rdata  in  DATA_W  memory read data

## Operation
- Internal state: FSM {IDLE, REQ, WAIT}, owner index, rr_ptr, payload registers, and a timeout counter sized $clog2(TIMEOUT_CYC+1).
- IDLE:
  - Pick the first requester with req_valid set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - In the same cycle, assert req_ready for the winner, latch its payload, set owner to the winner, and set rr_ptr to (winner+1) mod NUM_REQ.
  - Go to REQ.
  - If no requester is valid, stay in IDLE and hold rr_ptr.
- REQ:
  - Hold mem_req_valid=1 and the latched payload stable until mem_req_ready is high.
  - On that handshake, go to WAIT and clear the timeout counter.
  - If mem_resp_valid is also high in the handshake cycle, treat it as a zero-latency response: deliver it exactly as WAIT would, then go to IDLE.
- WAIT:
  - On mem_resp_valid: set resp_valid[owner]=1 for one cycle, drive resp_rdata=mem_resp_rdata and resp_err=0, then go to IDLE.
  - If the counter reaches TIMEOUT_CYC with no response: set resp_valid[owner]=1 and resp_err=1, drive resp_rdata=0, then go to IDLE.
- mem_resp_valid is ignored while in IDLE, and while in REQ when mem_req_ready is low.
- Requesters must be able to sink a response at any time; there is no resp_ready.
- Writes receive a response like reads; resp_rdata is don't-care for writes.
- The timeout counter saturates and never wraps.

## Timing
- Reset values:
  - FSM=IDLE, rr_ptr=0, owner=0, counter=0
  - req_ready=0, mem_req_valid=0, resp_valid=0, resp_err=0
  - resp_rdata=0, and all mem_* payload outputs 0
- req_ready is combinational from req_valid, FSM state and rr_ptr.
- A request accepted at cycle T drives mem_req_valid from T+1.
- resp_valid is combinational in the cycle mem_resp_valid is sampled high.
- After a response cycle R, the next accept happens no earlier than R+1. Minimum period is 3 cycles per transaction; 2 cycles with a zero-latency response.
- If reset asserts mid-transaction, the transaction is dropped with no response. The memory model is reset in the same domain.
- A requester's req_valid may drop before it is accepted. The payload is sampled only in the accept cycle.

## Structure
- Shared package grv_bus_pkg holds:
  - state enum arb_state_e {IDLE, REQ, WAIT}
  - mem_req_t struct {addr, wdata, wmask, wen}
  - default width constants
- Sub-module rr_pick: purely combinational. Takes the valid vector and a start pointer; outputs a one-hot grant and the grant index. It is reused later for the writeback-port arbiter.

## Test plan
- Single read: requester 1 issues addr 0x8000_0000; memory accepts at T+1 and responds at T+3 with 0xDEAD_BEEF_0000_0001 -> resp_valid[1] pulses at T+3 with that data, resp_err=0.
- Contention: both requesters valid continuously from reset -> grants alternate 0,1,0,1 over 4 transactions; req_ready is never high for both requesters in one cycle.
- Backpressure: mem_req_ready held low for 5 cycles -> mem_req_valid and mem_addr stay stable for all 5 cycles; accept occurs on the 6th.
- Timeout: TIMEOUT_CYC=8, memory never responds -> resp_valid[owner]=1 with resp_err=1 exactly 8 cycles after entering WAIT; FSM back in IDLE next cycle.
- Zero-latency: mem_req_ready and mem_resp_valid high in the same cycle -> the response is delivered that cycle and the next accept follows one cycle later.
- Reset in WAIT: assert reset asynchronously mid-transaction -> all outputs 0 immediately, no resp_valid, and requester 0 wins the first tie after reset.
